// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, the bubble
// encoding, control-level constants, FSM state encodings, the ack-timeout
// limit, and the PC increment helper.
package if_fetch_pkg;

    localparam int INST_ADDR_W = 16;   // InstAddrBus width
    localparam int INST_W      = 16;   // InstBus width

    // Encoding shown to decode when IF/ID holds a bubble
    localparam logic [INST_W-1:0] NOP_INST_ENC = 16'h0800;

    localparam logic RST_ENABLE  = 1'b1;
    localparam logic STALL_YES   = 1'b1;
    localparam logic STALL_NO    = 1'b0;
    localparam logic BRANCH_UP   = 1'b1;
    localparam logic BRANCH_DOWN = 1'b0;

    // Cycles spent in REQ without ack before the request is dropped and re-issued
    localparam int ACK_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_HOLD = 2'd2
    } if_state_e;

    // 16-bit PC increment; FFFF wraps to 0000
    function automatic logic [INST_ADDR_W-1:0] pc_inc(input logic [INST_ADDR_W-1:0] pc);
        return pc + 16'd1;
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding buffer for an instruction that returned from memory while
// decode was stalled. load captures {inst, pc}; drain or clear empties it.
module if_skid_buf
    import if_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   drain,
    input  logic                   clear,
    input  logic [INST_W-1:0]      inst_in,
    input  logic [INST_ADDR_W-1:0] pc_in,
    output logic                   valid,
    output logic [INST_W-1:0]      inst,
    output logic [INST_ADDR_W-1:0] pc
);

    // Buffer storage; data is kept on drain, only the valid flag drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            valid <= 1'b0;
            inst  <= NOP_INST_ENC;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            inst  <= inst_in;
            pc    <= pc_in;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, runs req/ack reads to the
// instruction SRAM, holds the IF/ID register, and honours decode stall and
// branch redirect with one delay slot.
// Optional feature macro: IF_ACK_TIMEOUT_EN (ack timeout with re-issue and
// fetch_err_o pulse). Without it REQ waits indefinitely and fetch_err_o is 0.
//
// Memory handshake: imem_req_o is held high with imem_addr_o stable until a
// cycle in which imem_ack_i is high; imem_rdata_i is valid in that same cycle
// and the transfer completes at that clock edge. Decode consumes IF/ID at any
// edge where inst_valid_o is high and stall_i is low.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] BOOT_ADDR = 16'h0000,
    parameter logic [INST_W-1:0]      NOP_INST  = NOP_INST_ENC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   branch_flag_i,
    input  logic [INST_ADDR_W-1:0] branch_addr_i,
    output logic                   imem_req_o,
    output logic [INST_ADDR_W-1:0] imem_addr_o,
    input  logic                   imem_ack_i,
    input  logic [INST_W-1:0]      imem_rdata_i,
    output logic [INST_ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0]      inst_o,
    output logic                   inst_valid_o,
    output logic                   fetch_err_o
);

    if_state_e                state;
    if_state_e                state_d;
    logic [INST_ADDR_W-1:0]   fetch_pc;
    logic                     redirect_pend;
    logic [INST_ADDR_W-1:0]   redirect_target;

    logic                     req;
    logic                     mem_to_ifid;
    logic                     buf_to_ifid;
    logic                     bubble;
    logic                     buf_load;
    logic                     buf_clear;
    logic                     pc_step;
    logic                     branch_now;
    logic                     tmo_hit;

    logic                     buf_valid;
    logic [INST_W-1:0]        buf_inst;
    logic [INST_ADDR_W-1:0]   buf_pc;

    // A redirect is only honoured when decode is not stalled
    assign branch_now = (stall_i == STALL_NO) && (branch_flag_i == BRANCH_UP);

`ifdef IF_ACK_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       err_q;

    assign tmo_hit     = (state == IF_REQ) && !imem_ack_i && (tmo_cnt == 8'(ACK_TIMEOUT - 1));
    assign fetch_err_o = err_q;

    // Count unanswered REQ cycles; the error pulse lines up with the req-low cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= tmo_hit;
            if ((state != IF_REQ) || imem_ack_i || tmo_hit) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign fetch_err_o = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state <= IF_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and per-cycle datapath controls
    always_comb begin
        state_d     = state;
        req         = 1'b0;
        mem_to_ifid = 1'b0;
        buf_to_ifid = 1'b0;
        bubble      = 1'b0;
        buf_load    = 1'b0;
        buf_clear   = 1'b0;
        pc_step     = 1'b0;
        case (state)
            IF_IDLE: begin
                buf_clear = 1'b1;
                state_d   = IF_REQ;
            end
            IF_REQ: begin
                req = 1'b1;
                if (imem_ack_i) begin
                    pc_step = 1'b1;
                    if (stall_i == STALL_YES) begin
                        buf_load = 1'b1;
                        state_d  = IF_HOLD;
                    end else begin
                        mem_to_ifid = 1'b1;
                    end
                end else begin
                    if (stall_i == STALL_NO) begin
                        bubble = 1'b1;
                    end
                    // Timeout: drop req for one cycle via IDLE, same fetch_pc
                    if (tmo_hit) begin
                        state_d = IF_IDLE;
                    end
                end
            end
            IF_HOLD: begin
                if (stall_i == STALL_NO) begin
                    buf_to_ifid = buf_valid;
                    state_d     = IF_REQ;
                end
            end
            default: state_d = IF_IDLE;
        endcase
    end

    assign imem_req_o  = req;
    assign imem_addr_o = req ? fetch_pc : '0;

    // Fetch PC and pending redirect; a redirect without ack waits for the delay-slot ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            fetch_pc        <= BOOT_ADDR;
            redirect_pend   <= 1'b0;
            redirect_target <= '0;
        end else if (pc_step) begin
            if (branch_now) begin
                fetch_pc <= branch_addr_i;
            end else if (redirect_pend) begin
                fetch_pc <= redirect_target;
            end else begin
                fetch_pc <= pc_inc(fetch_pc);
            end
            redirect_pend <= 1'b0;
        end else if ((state == IF_REQ) && branch_now) begin
            redirect_pend   <= 1'b1;
            redirect_target <= branch_addr_i;
        end
    end

    // IF/ID pipeline register: memory data, drained buffer, or bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            pc_o         <= '0;
            inst_o       <= NOP_INST;
            inst_valid_o <= 1'b0;
        end else if (mem_to_ifid) begin
            pc_o         <= pc_inc(fetch_pc);
            inst_o       <= imem_rdata_i;
            inst_valid_o <= 1'b1;
        end else if (buf_to_ifid) begin
            pc_o         <= buf_pc;
            inst_o       <= buf_inst;
            inst_valid_o <= 1'b1;
        end else if (bubble) begin
            inst_o       <= NOP_INST;
            inst_valid_o <= 1'b0;
        end
    end

    if_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (buf_load),
        .drain   (buf_to_ifid),
        .clear   (buf_clear),
        .inst_in (imem_rdata_i),
        .pc_in   (pc_inc(fetch_pc)),
        .valid   (buf_valid),
        .inst    (buf_inst),
        .pc      (buf_pc)
    );

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: directed phases drive stall/branch and a memory
// responder with programmable wait states; a monitor pops expected IF/ID
// words whenever decode consumes one.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [15:0] branch_addr_i = 16'h0000;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [15:0] imem_rdata_i = 16'h0000;
    logic [15:0] pc_o;
    logic [15:0] inst_o;
    logic        inst_valid_o;
    logic        fetch_err_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];          // {pc, inst} in consumption order
    logic        mon_en = 1'b0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic        pend_prev = 1'b0;
    logic [15:0] prev_addr = 16'h0000;
    int          cyc;

    if_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .branch_flag_i (branch_flag_i),
        .branch_addr_i (branch_addr_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .pc_o          (pc_o),
        .inst_o        (inst_o),
        .inst_valid_o  (inst_valid_o),
        .fetch_err_o   (fetch_err_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'h4000 + a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Expect instructions from addresses start..start+count-1, pc_o = addr+1
    task automatic push_seq(input logic [15:0] start, input int count);
        logic [15:0] a;
        for (int i = 0; i < count; i++) begin
            a = start + 16'(i);
            exp_q.push_back({a + 16'd1, mem_word(a)});
        end
    endtask

    // Wait (bounded) until IF/ID shows a valid instruction with the given pc_o
    task automatic wait_pc(input logic [15:0] target, output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            n++;
            if (inst_valid_o && (pc_o == target)) break;
        end
        check("wait_pc", {16'h0, pc_o}, {16'h0, target});
    endtask

    // ---------------- memory responder ----------------
    always @(negedge clk) begin
        if (imem_req_o) begin
            if (pend_prev) check("addr_stable", {16'h0, imem_addr_o}, {16'h0, prev_addr});
            if (wait_cnt >= ack_delay) begin
                imem_ack_i   = 1'b1;
                imem_rdata_i = mem_word(imem_addr_o);
                wait_cnt     = 0;
                pend_prev    = 1'b0;
            end else begin
                imem_ack_i = 1'b0;
                wait_cnt++;
                pend_prev  = 1'b1;
                prev_addr  = imem_addr_o;
            end
        end else begin
            imem_ack_i = 1'b0;
            wait_cnt   = 0;
            pend_prev  = 1'b0;
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [31:0] e;
        if (mon_en) begin
            if (inst_valid_o && !stall_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_inst", {pc_o, inst_o}, 32'hxxxx_xxxx);
                end else begin
                    e = exp_q.pop_front();
                    check("ifid_pc", {16'h0, pc_o}, {16'h0, e[31:16]});
                    check("ifid_inst", {16'h0, inst_o}, {16'h0, e[15:0]});
                end
            end else if (!inst_valid_o) begin
                check("bubble_nop", {16'h0, inst_o}, 32'h0000_0800);
            end
            check("fetch_err", {31'h0, fetch_err_o}, 32'h0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst_req", {31'h0, imem_req_o}, 32'h0);
        check("rst_addr", {16'h0, imem_addr_o}, 32'h0);
        check("rst_pc", {16'h0, pc_o}, 32'h0);
        check("rst_inst", {16'h0, inst_o}, 32'h0800);
        check("rst_valid", {31'h0, inst_valid_o}, 32'h0);
        check("rst_err", {31'h0, fetch_err_o}, 32'h0);

        // Sequential fetch from BOOT_ADDR, ack every cycle
        push_seq(16'h0000, 17);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        wait_pc(16'h0011, cyc);
        check("seq_latency", 32'(cyc), 32'd18);

        // Branch at pc 0x10 to 0x40, delay-slot ack one cycle late
        check("branch_req_addr", {16'h0, imem_addr_o}, 32'h0011);
        branch_flag_i = 1'b1;
        branch_addr_i = 16'h0040;
        ack_delay = 1;
        exp_q.push_back({16'h0012, mem_word(16'h0011)});
        push_seq(16'h0040, 3);
        @(posedge clk); #1;
        branch_flag_i = 1'b0;
        ack_delay = 0;
        @(posedge clk); #1;
        check("redirect_addr", {16'h0, imem_addr_o}, 32'h0040);
        wait_pc(16'h0043, cyc);

        // Two wait states per access: bubble, bubble, instruction
        push_seq(16'h0043, 2);
        ack_delay = 2;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("wait_valid", {31'h0, inst_valid_o}, (k % 3 == 2) ? 32'h1 : 32'h0);
        end
        ack_delay = 0;

        // Asynchronous reset in the middle of a request
        @(negedge clk); #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        mon_en = 1'b0;
        check("pre_rst_req", {31'h0, imem_req_o}, 32'h1);
        rst = 1'b1;
        #1;
        check("async_req", {31'h0, imem_req_o}, 32'h0);
        check("async_inst", {16'h0, inst_o}, 32'h0800);
        check("async_valid", {31'h0, inst_valid_o}, 32'h0);
        check("async_pc", {16'h0, pc_o}, 32'h0);
        push_seq(16'h0000, 5);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Ack at addr 5 under a 3-cycle stall
        wait_pc(16'h0005, cyc);
        check("stall_req_addr", {16'h0, imem_addr_o}, 32'h0005);
        stall_i = 1'b1;
        push_seq(16'h0005, 4);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("hold_req", {31'h0, imem_req_o}, 32'h0);
            check("hold_pc", {16'h0, pc_o}, 32'h0005);
            check("hold_inst", {16'h0, inst_o}, 32'h4004);
            if (i == 2) stall_i = 1'b0;
        end
        @(posedge clk); #1;
        check("drain_pc", {16'h0, pc_o}, 32'h0006);
        check("drain_inst", {16'h0, inst_o}, 32'h4005);
        check("resume_req", {31'h0, imem_req_o}, 32'h1);
        check("resume_addr", {16'h0, imem_addr_o}, 32'h0006);
        wait_pc(16'h0009, cyc);

        // Coincident branches: to FFFF, then from the FFFF delay slot to 0x20
        branch_flag_i = 1'b1;
        branch_addr_i = 16'hFFFF;
        exp_q.push_back({16'h000A, mem_word(16'h0009)});
        exp_q.push_back({16'h0000, mem_word(16'hFFFF)});
        push_seq(16'h0020, 2);
        @(posedge clk); #1;
        check("wrap_req_addr", {16'h0, imem_addr_o}, 32'hFFFF);
        branch_addr_i = 16'h0020;
        @(posedge clk); #1;
        branch_flag_i = 1'b0;
        check("wrap_pc", {16'h0, pc_o}, 32'h0000);
        check("wrap_inst", {16'h0, inst_o}, 32'h3FFF);
        check("target_addr", {16'h0, imem_addr_o}, 32'h0020);
        wait_pc(16'h0023, cyc);
        stall_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("final_hold_req", {31'h0, imem_req_o}, 32'h0);
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch stage for the 16-bit pipeline. It is the supplier side of the decode stage's interface. It owns the fetch PC and issues req/ack reads to the shared instruction SRAM port. It holds the IF/ID pipeline register and acts on the decode stage's stall and branch redirect (one delay slot).

Parameters:
BOOT_ADDR, 16'h0000, first fetch address after reset
NOP_INST, 16'h0800, encoding presented to decode as a bubble
ACK_TIMEOUT, 15, cycles to wait for imem_ack_i before re-issue (optional feature only)

Ports:
clk  in  1  pipeline clock
rst  in  1  reset, asynchronous, active-high (`RstEnable)
stall_i  in  1  hold IF/ID; from ctrl (OR of stall requests)
branch_flag_i  in  1  decode redirect request
branch_addr_i  in  16  redirect target
imem_req_o  out  1  read request, held until ack
imem_addr_o  out  16  read address, stable while req high
imem_ack_i  in  1  one-cycle completion; data valid same cycle
imem_rdata_i  in  16  instruction word
pc_o  out  16  IF/ID: fetch address + 1 of inst_o
inst_o  out  16  IF/ID instruction
inst_valid_o  out  1  IF/ID holds a real instruction
fetch_err_o  out  1  timeout pulse (optional feature; tied 0 otherwise)

Behaviour:
- Reset, async, any state:
  - fetch_pc=BOOT_ADDR, imem_req_o=0, imem_addr_o=0.
  - pc_o=0, inst_o=NOP_INST, inst_valid_o=0.
  - redirect_pend=0, buffer empty, state IDLE.
  - An outstanding request is abandoned; the memory side tolerates the dropped req.
- States: IDLE, REQ, HOLD.
- IDLE: one cycle after reset release, go to REQ.
- REQ (imem_req_o=1, imem_addr_o=fetch_pc):
  - ack and !stall_i: IF/ID gets inst_o=rdata, pc_o=fetch_pc+1, valid=1. fetch_pc advances (see redirect). Stay in REQ. Throughput is 1 instruction/cycle when ack arrives in the same cycle as req.
  - ack and stall_i: capture rdata and fetch_pc+1 into a 1-entry buffer. IF/ID unchanged. Go to HOLD with req low.
  - No ack and !stall_i: IF/ID gets the bubble (NOP_INST, valid=0; pc_o unchanged).
  - No ack and stall_i: IF/ID unchanged.
- HOLD (req=0):
  - While stall_i: stay.
  - On !stall_i: IF/ID gets the buffer contents, valid=1, and the state goes to REQ.
- Redirect is sampled only when stall_i=0. The instruction delivered next after the branch is the delay slot and is always executed.
  - Branch in the same cycle as ack: fetch_pc <= branch_addr_i.
  - Branch with no ack: redirect_pend=1 and the target is latched. On the delay-slot ack, fetch_pc <= target and pend clears.
  - Otherwise fetch_pc <= fetch_pc+1.
- Address arithmetic is 16-bit with wrap: FFFF+1=0000.
- Branch asserted while in HOLD cannot occur, because stall_i is high; if it does, it is ignored.

Optional Feature:
IF_ACK_TIMEOUT_EN:
- When defined: a counter runs while in REQ without ack. When it reaches ACK_TIMEOUT, imem_req_o drops for 1 cycle, fetch_err_o pulses for 1 cycle, and the request is re-issued to the same address. The counter clears on ack or reset.
- When undefined: no counter, REQ waits indefinitely, and fetch_err_o is constant 0.

Decomposition:
- defines.v gets:
  - NOP instruction encoding.
  - Bus widths (InstAddrBus, InstBus).
  - RstEnable, StallYes/StallNo, BranchFlagUp/Down.
  - State encodings IF_IDLE/IF_REQ/IF_HOLD.
- One natural sub-module: if_skid_buf. It is the 1-entry buffer (valid, inst, pc) with load/drain/clear.

Test Plan:
- Sequential fetch, ack every cycle from BOOT_ADDR=0, memory[i]=16'h4000+i → inst_o 4000,4001,4002 on consecutive cycles; pc_o 1,2,3; valid=1.
- Wait states, ack 2 cycles after req → two bubble cycles (inst_o=0800, valid=0), then instruction; imem_addr_o stable throughout.
- Ack at addr 5 while stall_i=1 for 3 cycles → IF/ID unchanged, req low. On release, inst_o=mem[5], pc_o=6, and the next req addr is 6.
- Branch at pc 0x10 with branch_addr_i=0x40, delay-slot ack pending 1 cycle → delay slot mem[0x11] delivered, then next req addr 0x40, pc_o 0x41.
- Branch coincident with ack; fetch_pc=0xFFFF wrap → delay slot at FFFF, pc_o=0000, next addr=branch target.
- rst asserted mid-REQ → imem_req_o=0 and inst_o=0800 immediately (async). After release, fetch restarts at BOOT_ADDR.
- (IF_ACK_TIMEOUT_EN) no ack for 15 cycles → fetch_err_o one pulse, req low 1 cycle, re-issue at same address.
